ifetch_queue: RTL and testbench

- Instruction fetch front end: drives synchronous ROM word address, captures returned instruction words into a small prefetch FIFO, and presents them with their PC to the decode/execute sequencer through a valid/ready handshake.
- Accepts a redirect (branch/jump target) from the sequencer, which flushes the queue and any in-flight ROM read.
- Replaces the sequencer's direct PC-to-ROM addressing, so fetch overlaps with decode/execute/write-back.

---
 rtl/ifetch_queue_pkg.sv | 22 ++
 rtl/ifetch_queue_sync_fifo.sv | 72 +++++++
 rtl/ifetch_queue.sv | 99 +++++++++
 tb/tb_ifetch_queue.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared fetch/decode constants: instruction width, default geometry, reset PC,
// filler NOP encoding and the opcode fields the decoder keys on.
// Latency: n/a (declarations only). Backpressure: n/a.
package ifetch_queue_pkg;

    localparam int          INSN_W       = 32;
    localparam int          DEF_ADDR_W   = 7;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    // addi x0, x0, 0
    localparam logic [31:0] INSN_NOP     = 32'h0000_0013;

    // Major opcode field insn[6:2]
    localparam logic [4:0]  OP_IMM       = 5'b00100;
    localparam logic [4:0]  OP_JAL       = 5'b11011;

    // Fetch is word-granular: the two low PC bits are forced to zero.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush; head word shown directly from storage.
// Latency: a word pushed at an edge is at the head in the following cycle.
// Backpressure: caller must not push when full unless popping the same cycle.
//
// Ports: clk, rst (sync, active-high), flush_i (clears contents, wins over
// push/pop), push_i/push_dat_i, pop_i (ignored when empty),
// head_vld_o/head_dat_o, count_o (0..DEPTH).
module ifetch_queue_sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             head_vld_o,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CNT_W-1:0] count_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q,  count_d;
    logic                        do_pop;

    assign do_pop = pop_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap naturally.
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_vld_o = (count_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !do_pop && !flush_i && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: addresses a sync ROM, queues returned words with
// their PC, and hands them to the sequencer; redirect flushes and restarts.
// Latency: 2 cycles from reset release / redirect edge to first insn_valid_o.
// Backpressure: issues a ROM read only while FIFO entries + in-flight read
// (net of this cycle's pop) leave room, so the FIFO never overflows.
//
// Ports: clk, rst (sync, active-high); rom_addr_o/rom_data_i (ROM word
// address, data one cycle later); insn_valid_o/insn_o/insn_pc_o/insn_ready_i
// (head handshake); redirect_valid_i/redirect_pc_i (flush and new target).
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INSN_W-1:0] rom_data_i,
    output logic              insn_valid_o,
    output logic [INSN_W-1:0] insn_o,
    output logic [31:0]       insn_pc_o,
    input  logic              insn_ready_i,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam int ENT_W = INSN_W + 32;

    logic [31:0]       fetch_pc_q,    fetch_pc_d;
    logic              inflight_q,    inflight_d;
    logic [31:0]       inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_vld;
    logic [ENT_W-1:0]  fifo_head;
    logic [OCC_W-1:0]  occupancy;
    logic              pop;
    logic              push;
    logic              issue;

    // A redirect discards the head, so it is never reported as consumed.
    assign pop  = fifo_vld & insn_ready_i & ~redirect_valid_i;
    assign push = inflight_q & ~redirect_valid_i;

    // Credit: slots already committed (queued + in flight) after this pop.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue     = ~redirect_valid_i & (occupancy < OCC_W'(DEPTH));

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid_i) begin
            fetch_pc_d = align_pc(redirect_pc_i);
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // When nothing issues, the ROM harmlessly re-reads the held address.
    assign rom_addr_o = fetch_pc_q[ADDR_W+1:2];

    ifetch_queue_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_valid_i),
        .push_i     (push),
        .push_dat_i ({rom_data_i, inflight_pc_q}),
        .pop_i      (pop),
        .head_vld_o (fifo_vld),
        .head_dat_o (fifo_head),
        .count_o    (fifo_count)
    );

    assign insn_valid_o = fifo_vld;
    assign insn_o       = fifo_head[ENT_W-1:32];
    assign insn_pc_o    = fifo_head[31:0];

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
    import ifetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  rom_addr;
    logic [31:0] rom_data;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ifetch_queue #(
        .ADDR_W   (7),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rom_addr_o       (rom_addr),
        .rom_data_i       (rom_data),
        .insn_valid_o     (insn_valid),
        .insn_o           (insn),
        .insn_pc_o        (insn_pc),
        .insn_ready_i     (insn_ready),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc)
    );

    function automatic logic [31:0] rom_word(input logic [6:0] idx);
        return 32'h1000_0000 + {25'd0, idx};
    endfunction

    // Synchronous ROM: address sampled at the edge, data valid next cycle.
    always @(posedge clk) rom_data <= rst ? INSN_NOP : rom_word(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Consume n words with ready held high; compare each against the scoreboard.
    task automatic drain(input int n, input int budget, output int cycles);
        int          got;
        logic [31:0] e;
        got    = 0;
        cycles = 0;
        insn_ready = 1'b1;
        while (got < n && cycles < budget) begin
            if (insn_valid) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("insn_pc", insn_pc, e);
                check("insn", insn, rom_word(e[8:2]));
                got++;
            end
            step();
            cycles++;
        end
        check("drain_count", 32'(got), 32'(n));
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input logic [31:0] aligned);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exp_q.delete();
        check("redir_vld_r0", {31'd0, insn_valid}, 32'd0);
        check("redir_addr", {25'd0, rom_addr}, {25'd0, aligned[8:2]});
        step();
        check("redir_vld_r1", {31'd0, insn_valid}, 32'd0);
        step();
        check("redir_vld_r2", {31'd0, insn_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and first-fetch latency, then full-rate streaming.
        rst = 1'b1;
        step();
        step();
        check("rst_vld", {31'd0, insn_valid}, 32'd0);
        check("rst_addr", {25'd0, rom_addr}, 32'd0);
        check("rst_insn", insn, 32'd0);
        check("rst_pc", insn_pc, 32'd0);
        rst = 1'b0;
        insn_ready = 1'b1;
        step();
        check("lat_vld_e1", {31'd0, insn_valid}, 32'd0);
        step();
        check("lat_vld_e2", {31'd0, insn_valid}, 32'd1);
        push_exp(32'h0, 8);
        drain(8, 16, cyc);
        check("tput_cycles", 32'(cyc), 32'd8);

        // Backpressure: FIFO fills to DEPTH, fetch stalls, then resumes gap-free.
        rst = 1'b1;
        insn_ready = 1'b0;
        step();
        rst = 1'b0;
        exp_q.delete();
        repeat (10) step();
        check("sat_vld", {31'd0, insn_valid}, 32'd1);
        check("sat_addr", {25'd0, rom_addr}, 32'd4);
        check("sat_pc", insn_pc, 32'h0);
        step();
        check("hold_pc", insn_pc, 32'h0);
        check("hold_insn", insn, rom_word(7'd0));
        check("hold_addr", {25'd0, rom_addr}, 32'd4);
        push_exp(32'h0, 12);
        drain(12, 24, cyc);
        check("resume_cycles", 32'(cyc), 32'd12);

        // Redirect while pc 8 is at the head with ready high: pc 8 dropped.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        push_exp(32'h0, 2);
        drain(2, 8, cyc);
        check("pre_redir_vld", {31'd0, insn_valid}, 32'd1);
        check("pre_redir_pc", insn_pc, 32'h8);
        redirect_to(32'h40, 32'h40);
        push_exp(32'h40, 4);
        drain(4, 12, cyc);

        // Unaligned target is word-aligned.
        redirect_to(32'h23, 32'h20);
        push_exp(32'h20, 3);
        drain(3, 10, cyc);

        // ROM address wraps, PC keeps counting.
        redirect_to(32'h1F8, 32'h1F8);
        check("wrap_addr", {25'd0, rom_addr}, 32'd0);
        push_exp(32'h1F8, 4);
        drain(4, 12, cyc);

        // Reset mid-stream with three words queued: nothing stale survives.
        rst = 1'b1;
        insn_ready = 1'b0;
        step();
        rst = 1'b0;
        exp_q.delete();
        repeat (4) step();
        check("pre_rst_vld", {31'd0, insn_valid}, 32'd1);
        check("pre_rst_pc", insn_pc, 32'h0);
        rst = 1'b1;
        step();
        check("mrst_vld", {31'd0, insn_valid}, 32'd0);
        rst = 1'b0;
        insn_ready = 1'b1;
        step();
        check("mrst_vld_e1", {31'd0, insn_valid}, 32'd0);
        step();
        check("mrst_vld_e2", {31'd0, insn_valid}, 32'd1);
        push_exp(32'h0, 6);
        drain(6, 12, cyc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
